btn_pulse: RTL and testbench
============================

# btn_pulse

Button conditioner that sits directly upstream of the 5-bit counter and drives its `en` input. It synchronises a raw, bouncing push-button and debounces it in both directions. It emits exactly one single-cycle `pulse` per accepted press, plus optional auto-repeat pulses while the button is held. It runs in the same clock domain as the counter.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronised samples required to accept a press or release; minimum 1.
- `HOLD_CYCLES`, 20: cycles from the press pulse to the first repeat pulse; minimum 1.
- `REPEAT_CYCLES`, 5: cycles between consecutive repeat pulses; minimum 2.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low; asserts immediately, deassertion is externally synchronised to `clk`.
- `btn_in`  in  1  raw button, asynchronous to `clk`, active-high, may bounce.
- `repeat_en`  in  1  synchronous; 1 enables auto-repeat while held.
- `pulse`  out  1  registered, one-cycle strobe per accepted press or repeat; connects to counter `en`.
- `level`  out  1  registered debounced button level.

## Operation
- **Synchroniser:** two flops `btn_in` → `s1` → `btn_s`, both cleared by reset. Only `btn_s` is used by the FSM.
- **Counters:** internal counters are sized to hold the largest parameter and saturate at their target; they never wrap.
- **FSM states:**
  - `IDLE` (level 0): `btn_s`=1 → `PRESS_WAIT`; stable count = 1.
  - `PRESS_WAIT` (level 0): `btn_s`=0 → `IDLE`, count cleared, no pulse. Otherwise count++. On reaching `DEBOUNCE_CYCLES` → `HELD`, `level`←1, `pulse`←1 for one cycle, hold counter cleared.
  - `HELD` (level 1): `btn_s`=0 → `RELEASE_WAIT`, stable count = 1. Else, if `repeat_en`=1 and the hold counter reaches `HOLD_CYCLES` → `REPEAT`, `pulse`←1, repeat counter cleared. If `repeat_en`=0, the hold counter is held at 0.
  - `REPEAT` (level 1): `btn_s`=0 → `RELEASE_WAIT`. `repeat_en`=0 → `HELD`, hold counter cleared, no pulse. Else, each time the repeat counter reaches `REPEAT_CYCLES` → `pulse`←1 and the counter restarts.
  - `RELEASE_WAIT` (level 1): `btn_s`=1 → `HELD`, hold counter cleared, no pulse. Else count++. On reaching `DEBOUNCE_CYCLES` → `IDLE`, `level`←0, no pulse.
- **Pulse rules:** `pulse` is 0 in every cycle not named above. No pulse is ever generated on release. At most one pulse per cycle.
- **Simultaneous events:** release detection (`btn_s`=0) takes priority over a due repeat pulse in the same cycle.
- **Reset:** `rst`=0 at any time, including mid-press or mid-repeat, immediately forces `IDLE`, all counters 0, `s1`=`btn_s`=0, `pulse`=0, `level`=0. A button still held when `rst` rises is treated as a new press: it passes through full debounce and produces one pulse.

## Timing
- **Reset values:** `pulse`=0, `level`=0.
- **Press latency:** let k be the first edge at which `btn_in` is sampled high, with `btn_in` stable afterwards. `pulse` and `level` become 1 at edge k+`DEBOUNCE_CYCLES`+2. `pulse` returns to 0 at the next edge.
- **Release latency:** let r be the first edge sampling `btn_in` low, with `btn_in` stable afterwards. `level` becomes 0 at edge r+`DEBOUNCE_CYCLES`+2.
- **Repeat schedule:** let press pulse edge = P. With `repeat_en`=1 throughout, repeat pulses occur at P+`HOLD_CYCLES`, then every `REPEAT_CYCLES` edges after that, until release is detected.
- **Bounce rejection:** a high or low glitch shorter than `DEBOUNCE_CYCLES` synchronised samples changes neither output.

## Test plan
All scenarios use defaults 4 / 20 / 5; edge 0 is the first edge sampling `btn_in` high.
- **Reset:** `rst`=0 while toggling `btn_in` and `repeat_en` → `pulse`=0 and `level`=0 throughout. `rst` release with `btn_in`=0 → outputs stay 0.
- **Clean press, `repeat_en`=0:** `btn_in` held high 40 cycles → exactly one pulse at edge 6, `level`=1 from edge 6. After `btn_in` falls (first low sample at edge 40), `level`=0 at edge 46. No further pulse.
- **Bounce:** `btn_in` high bursts of 1, 2, 3 cycles separated by 2 low cycles → zero pulses, `level` stays 0. Then a 10-cycle bouncy release during `HELD` (low bursts of 1–3 cycles) → `level` stays 1, no pulses.
- **Auto-repeat, `repeat_en`=1:** `btn_in` high for 48 cycles → pulses at edges 6, 26, 31, 36, 41, 46 only (6 total). `level` falls at edge 54. Driving the counter from this block, starting at 0 → `out`=6.
- **Repeat disable mid-hold:** `repeat_en` dropped at edge 33 → no pulse after 31 while held. Re-raised at edge 40 → next pulse at edge 60.
- **Reset mid-repeat:** `rst`=0 at edge 38 while held → `pulse`=0 and `level`=0 immediately. `rst` released with `btn_in` still high, so that edge 100 is the first sampling edge → single pulse at edge 106, then repeats at 126, 131, ….

Source files
------------

// File: rtl/btn_pulse.sv
// Button conditioner: two-flop synchroniser, bidirectional debounce, and a
// single-cycle pulse per accepted press with optional auto-repeat while held.
module btn_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES     = 20,
  parameter int unsigned REPEAT_CYCLES   = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic repeat_en,
  output logic pulse,
  output logic level
);

  localparam int unsigned MAX_A = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int unsigned MAX_C = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
  localparam int unsigned CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] DEB_LIM  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] REP_LIM  = CW'(REPEAT_CYCLES);
  localparam logic [CW-1:0] HOLD_DUE = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_DUE  = CW'(REPEAT_CYCLES - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REPEAT,
    RELEASE_WAIT
  } state_t;

  state_t        state;
  logic          s1;
  logic          btn_s;
  logic [CW-1:0] stab_cnt;
  logic [CW-1:0] hold_cnt;
  logic [CW-1:0] rep_cnt;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic [CW-1:0] lim);
    return (v >= lim) ? lim : v + ONE;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1       <= 1'b0;
      btn_s    <= 1'b0;
      state    <= IDLE;
      stab_cnt <= '0;
      hold_cnt <= '0;
      rep_cnt  <= '0;
      pulse    <= 1'b0;
      level    <= 1'b0;
    end else begin
      // synchroniser stage: only btn_s feeds the state machine
      s1    <= btn_in;
      btn_s <= s1;
      pulse <= 1'b0;

      // debounce / repeat state machine
      case (state)
        IDLE: begin
          if (btn_s) begin
            state    <= PRESS_WAIT;
            stab_cnt <= ONE;
          end else begin
            stab_cnt <= '0;
          end
        end

        PRESS_WAIT: begin
          if (!btn_s) begin
            state    <= IDLE;
            stab_cnt <= '0;
          end else if (stab_cnt >= DEB_LIM) begin
            state    <= HELD;
            level    <= 1'b1;
            pulse    <= 1'b1;
            hold_cnt <= '0;
            stab_cnt <= '0;
          end else begin
            stab_cnt <= sat_inc(stab_cnt, DEB_LIM);
          end
        end

        HELD: begin
          if (!btn_s) begin
            state    <= RELEASE_WAIT;
            stab_cnt <= ONE;
          end else if (!repeat_en) begin
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_DUE) begin
            state   <= REPEAT;
            pulse   <= 1'b1;
            rep_cnt <= '0;
          end else begin
            hold_cnt <= sat_inc(hold_cnt, HOLD_LIM);
          end
        end

        REPEAT: begin
          // release wins over a repeat that falls due in the same cycle
          if (!btn_s) begin
            state    <= RELEASE_WAIT;
            stab_cnt <= ONE;
          end else if (!repeat_en) begin
            state    <= HELD;
            hold_cnt <= '0;
          end else if (rep_cnt == REP_DUE) begin
            pulse   <= 1'b1;
            rep_cnt <= '0;
          end else begin
            rep_cnt <= sat_inc(rep_cnt, REP_LIM);
          end
        end

        RELEASE_WAIT: begin
          if (btn_s) begin
            state    <= HELD;
            hold_cnt <= '0;
            stab_cnt <= '0;
          end else if (stab_cnt >= DEB_LIM) begin
            state    <= IDLE;
            level    <= 1'b0;
            stab_cnt <= '0;
          end else begin
            stab_cnt <= sat_inc(stab_cnt, DEB_LIM);
          end
        end

        default: begin
          state    <= IDLE;
          level    <= 1'b0;
          stab_cnt <= '0;
          hold_cnt <= '0;
          rep_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_pulse.sv
// Directed bench for btn_pulse with default parameters 4 / 20 / 5.
// Edge numbers are relative: edge 0 is the first edge sampling the new input.
module tb_btn_pulse;

  logic clk;
  logic rst;
  logic btn_in;
  logic repeat_en;
  logic pulse;
  logic level;

  int total;
  int bad;
  int e;

  btn_pulse #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(20),
    .REPEAT_CYCLES(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .repeat_en(repeat_en),
    .pulse(pulse),
    .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled and inputs driven 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    e = e + 1;
  endtask

  task automatic test_reset();
    logic pattern [12];
    for (int i = 0; i < 12; i++) pattern[i] = ((i % 3) == 0);
    for (int i = 0; i < 12; i++) begin
      btn_in    = pattern[i];
      repeat_en = (i % 2) == 1;
      tick();
      total++;
      if (pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse cyc=%0d got=%b want=0", i, pulse); end
      total++;
      if (level !== 1'b0) begin bad++; $display("FAIL reset_level cyc=%0d got=%b want=0", i, level); end
    end
    btn_in    = 1'b0;
    repeat_en = 1'b0;
    rst       = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (pulse !== 1'b0 || level !== 1'b0) begin
        bad++;
        $display("FAIL reset_release cyc=%0d got pulse=%b level=%b want 0/0", i, pulse, level);
      end
    end
  endtask

  task automatic test_clean_press();
    logic exp_p, exp_l;
    int npulse;
    npulse    = 0;
    repeat_en = 1'b0;
    e         = -1;
    btn_in    = 1'b1;
    while (e < 52) begin
      tick();
      exp_p = (e == 6);
      exp_l = (e >= 6) && (e < 46);
      if (pulse === 1'b1) npulse++;
      total++;
      if (pulse !== exp_p) begin bad++; $display("FAIL clean_pulse edge=%0d got=%b want=%b", e, pulse, exp_p); end
      total++;
      if (level !== exp_l) begin bad++; $display("FAIL clean_level edge=%0d got=%b want=%b", e, level, exp_l); end
      if (e == 39) btn_in = 1'b0;
    end
    total++;
    if (npulse != 1) begin bad++; $display("FAIL clean_count got=%0d want=1", npulse); end
  endtask

  task automatic test_bounce();
    logic press_pat [20];
    logic rel_pat [10];
    int npulse;
    // high bursts of 1, 2, 3 with 2-cycle low gaps, then quiet
    press_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    // low bursts of 1, 2, 3 separated by high samples
    rel_pat   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    repeat_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      btn_in = press_pat[i];
      tick();
      total++;
      if (pulse !== 1'b0 || level !== 1'b0) begin
        bad++;
        $display("FAIL bounce_press cyc=%0d got pulse=%b level=%b want 0/0", i, pulse, level);
      end
    end
    npulse = 0;
    btn_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pulse === 1'b1) npulse++;
    end
    total++;
    if (npulse != 1 || level !== 1'b1) begin
      bad++;
      $display("FAIL bounce_accept got pulses=%0d level=%b want 1/1", npulse, level);
    end
    for (int i = 0; i < 18; i++) begin
      btn_in = (i < 10) ? rel_pat[i] : 1'b1;
      tick();
      total++;
      if (pulse !== 1'b0 || level !== 1'b1) begin
        bad++;
        $display("FAIL bounce_release cyc=%0d got pulse=%b level=%b want 0/1", i, pulse, level);
      end
    end
    btn_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (pulse !== 1'b0) begin bad++; $display("FAIL bounce_final_pulse cyc=%0d got=%b want=0", i, pulse); end
    end
    total++;
    if (level !== 1'b0) begin bad++; $display("FAIL bounce_final_level got=%b want=0", level); end
  endtask

  task automatic test_auto_repeat();
    logic exp_p, exp_l;
    int npulse;
    npulse    = 0;
    repeat_en = 1'b1;
    e         = -1;
    btn_in    = 1'b1;
    while (e < 60) begin
      tick();
      exp_p = (e inside {6, 26, 31, 36, 41, 46});
      exp_l = (e >= 6) && (e < 54);
      if (pulse === 1'b1) npulse++;
      total++;
      if (pulse !== exp_p) begin bad++; $display("FAIL repeat_pulse edge=%0d got=%b want=%b", e, pulse, exp_p); end
      total++;
      if (level !== exp_l) begin bad++; $display("FAIL repeat_level edge=%0d got=%b want=%b", e, level, exp_l); end
      if (e == 47) btn_in = 1'b0;
    end
    total++;
    if (npulse != 6) begin bad++; $display("FAIL repeat_count got=%0d want=6", npulse); end
    repeat_en = 1'b0;
  endtask

  task automatic test_repeat_disable();
    logic exp_p, exp_l;
    repeat_en = 1'b1;
    e         = -1;
    btn_in    = 1'b1;
    while (e < 76) begin
      tick();
      exp_p = (e inside {6, 26, 31, 60, 65});
      exp_l = (e >= 6) && (e < 73);
      total++;
      if (pulse !== exp_p) begin bad++; $display("FAIL disable_pulse edge=%0d got=%b want=%b", e, pulse, exp_p); end
      total++;
      if (level !== exp_l) begin bad++; $display("FAIL disable_level edge=%0d got=%b want=%b", e, level, exp_l); end
      if (e == 33) repeat_en = 1'b0;
      if (e == 40) repeat_en = 1'b1;
      if (e == 66) btn_in = 1'b0;
    end
    repeat_en = 1'b0;
  endtask

  task automatic test_reset_mid_repeat();
    logic exp_p, exp_l;
    repeat_en = 1'b1;
    e         = -1;
    btn_in    = 1'b1;
    while (e < 38) begin
      tick();
      exp_p = (e inside {6, 26, 31, 36});
      exp_l = (e >= 6);
      total++;
      if (pulse !== exp_p || level !== exp_l) begin
        bad++;
        $display("FAIL midrst_pre edge=%0d got pulse=%b level=%b want %b/%b", e, pulse, level, exp_p, exp_l);
      end
    end
    rst = 1'b0;
    #1;
    total++;
    if (pulse !== 1'b0 || level !== 1'b0) begin
      bad++;
      $display("FAIL midrst_async got pulse=%b level=%b want 0/0", pulse, level);
    end
    while (e < 99) begin
      tick();
      total++;
      if (pulse !== 1'b0 || level !== 1'b0) begin
        bad++;
        $display("FAIL midrst_hold edge=%0d got pulse=%b level=%b want 0/0", e, pulse, level);
      end
    end
    rst = 1'b1;
    while (e < 132) begin
      tick();
      exp_p = (e inside {106, 126, 131});
      exp_l = (e >= 106);
      total++;
      if (pulse !== exp_p) begin bad++; $display("FAIL midrst_pulse edge=%0d got=%b want=%b", e, pulse, exp_p); end
      total++;
      if (level !== exp_l) begin bad++; $display("FAIL midrst_level edge=%0d got=%b want=%b", e, level, exp_l); end
    end
    btn_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      total++;
      if (pulse !== 1'b0) begin bad++; $display("FAIL midrst_release_pulse edge=%0d got=%b want=0", e, pulse); end
    end
    total++;
    if (level !== 1'b0) begin bad++; $display("FAIL midrst_release_level got=%b want=0", level); end
    repeat_en = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    e         = 0;
    rst       = 1'b0;
    btn_in    = 1'b0;
    repeat_en = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_repeat_disable();
    test_reset_mid_repeat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
